// File: rtl/ring_mem_ctrl.sv
// ring_mem_ctrl: ring-side memory controller with address/write-data queues, 8-beat line
// bursts and a two-stage read-return pipeline. Define RING_METERS_EN for slot-type meters.
module ring_mem_ctrl #(
   parameter int MBITS    = 24,
   parameter int MA_LOG   = 9,
   parameter int MD_LOG   = 12,
   parameter int RD_DELAY = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      ring_data,
   input  logic [3:0]       ring_type,
   input  logic [3:0]       ring_src,
   output logic [MBITS-1:0] mem_addr,
   output logic             mem_re,
   output logic             mem_we,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   output logic [31:0]      rd_data,
   output logic [3:0]       rd_dest,
   output logic             ovf,
   output logic             badaddr
);
   localparam int LW      = MBITS - 3;
   localparam int AQ_SIZE = 1 << MA_LOG;
   localparam int DQ_SIZE = 1 << MD_LOG;
   localparam int DLY_W   = (RD_DELAY > 1) ? $clog2(RD_DELAY) : 1;
   localparam logic [MA_LOG:0] AQ_LIM     = (MA_LOG+1)'(AQ_SIZE - 4);
   localparam logic [MD_LOG:0] DQ_LIM     = (MD_LOG+1)'(DQ_SIZE - 4);
   localparam logic [MD_LOG:0] LINE_WORDS = (MD_LOG+1)'(8);
   localparam logic [31:0]     IDLE_WORD  = 32'hDEADBEEF;
   localparam logic [3:0]      T_ADDR     = 4'd2;
   localparam logic [3:0]      T_WDATA    = 4'd3;

   typedef enum logic [1:0] {IDLE, DELAY, BURST} state_t;

   function automatic logic line_out_of_range(input logic [27:0] line);
      return line[27:LW] != '0;
   endfunction

   // address queue entries: {src[3:0], read, line[27:0]}
   logic [32:0]       aq_mem [AQ_SIZE];
   logic [MA_LOG-1:0] aq_wp, aq_rp;
   logic [MA_LOG:0]   aq_cnt;
   logic              aq_push_req, aq_full, aq_push, aq_pop, aq_valid;
   logic [31:0]       dq_mem [DQ_SIZE];
   logic [MD_LOG-1:0] dq_wp, dq_rp;
   logic [MD_LOG:0]   dq_cnt;
   logic              dq_push_req, dq_full, dq_push, dq_pop;

   state_t           state;
   logic [2:0]       beat;
   logic [DLY_W-1:0] dly;
   logic             start, wait_dly;

   logic [32:0]   aq_head;
   logic [3:0]    head_src;
   logic          head_rd, head_bad, head_met;
   logic [27:0]   head_line;
   logic [3:0]    cur_src;
   logic          cur_rd, cur_bad, cur_met;
   logic [LW-1:0] cur_line;
   logic          sel_rd, sel_bad, sel_met;
   logic [LW-1:0] sel_line;

   logic          vld_p0, dead_p0;
   logic [3:0]    dest_p0;
   logic [31:0]   ret_word;

   assign aq_push_req = ring_type == T_ADDR;
   assign aq_full     = aq_cnt > AQ_LIM;
   assign aq_push     = aq_push_req && !aq_full;
   assign aq_valid    = aq_cnt != '0;
   assign dq_push_req = ring_type == T_WDATA;
   assign dq_full     = dq_cnt > DQ_LIM;
   assign dq_push     = dq_push_req && !dq_full;
   assign aq_pop      = (state == BURST) && (beat == 3'd7);
   assign dq_pop      = (state == BURST) && !cur_rd;

   always_ff @(posedge clk) begin
      if (aq_push) aq_mem[aq_wp] <= {ring_src, ring_data[28:0]};
      if (dq_push) dq_mem[dq_wp] <= ring_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aq_wp  <= '0;
         aq_rp  <= '0;
         aq_cnt <= '0;
         dq_wp  <= '0;
         dq_rp  <= '0;
         dq_cnt <= '0;
         ovf    <= 1'b0;
      end else begin
         if (aq_push) aq_wp <= aq_wp + 1'b1;
         if (aq_pop)  aq_rp <= aq_rp + 1'b1;
         if (aq_push && !aq_pop)      aq_cnt <= aq_cnt + 1'b1;
         else if (aq_pop && !aq_push) aq_cnt <= aq_cnt - 1'b1;
         if (dq_push) dq_wp <= dq_wp + 1'b1;
         if (dq_pop)  dq_rp <= dq_rp + 1'b1;
         if (dq_push && !dq_pop)      dq_cnt <= dq_cnt + 1'b1;
         else if (dq_pop && !dq_push) dq_cnt <= dq_cnt - 1'b1;
         if ((aq_push_req && aq_full) || (dq_push_req && dq_full)) ovf <= 1'b1;
      end
   end

   assign aq_head   = aq_mem[aq_rp];
   assign head_src  = aq_head[32:29];
   assign head_rd   = aq_head[28];
   assign head_line = aq_head[27:0];
   assign mem_wdata = dq_mem[dq_rp];
`ifdef RING_METERS_EN
   assign head_met  = &head_line[27:1];
`else
   assign head_met  = 1'b0;
`endif
   assign head_bad  = line_out_of_range(head_line) && !head_met;

   // a burst launched straight from IDLE uses the queue head; from DELAY the latched copy
   assign sel_rd   = (state == IDLE) ? head_rd  : cur_rd;
   assign sel_bad  = (state == IDLE) ? head_bad : cur_bad;
   assign sel_met  = (state == IDLE) ? head_met : cur_met;
   assign sel_line = (state == IDLE) ? head_line[LW-1:0] : cur_line;

   always_comb begin
      start    = 1'b0;
      wait_dly = 1'b0;
      case (state)
         IDLE: begin
            if (aq_valid) begin
               if (head_rd) begin
                  if (RD_DELAY == 0) start = 1'b1;
                  else               wait_dly = 1'b1;
               end else if (dq_cnt >= LINE_WORDS) begin
                  start = 1'b1;
               end
            end
         end
         DELAY:   start = (dly == '0);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         beat    <= '0;
         dly     <= '0;
         mem_re  <= 1'b0;
         mem_we  <= 1'b0;
         badaddr <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (wait_dly) begin
                  state <= DELAY;
                  dly   <= DLY_W'(RD_DELAY - 1);
               end
            end
            DELAY: dly <= dly - 1'b1;
            BURST: begin
               if (beat == 3'd7) begin
                  state  <= IDLE;
                  mem_re <= 1'b0;
                  mem_we <= 1'b0;
               end else begin
                  beat <= beat + 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
         if (start) begin
            state  <= BURST;
            beat   <= '0;
            mem_re <= sel_rd && !sel_bad && !sel_met;
            mem_we <= !sel_rd && !sel_bad && !sel_met;
            if (sel_bad) badaddr <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         cur_src  <= head_src;
         cur_rd   <= head_rd;
         cur_bad  <= head_bad;
         cur_met  <= head_met;
         cur_line <= head_line[LW-1:0];
      end
      if (start)                                 mem_addr <= {sel_line, 3'd0};
      else if (state == BURST && beat != 3'd7)   mem_addr <= {cur_line, beat + 3'd1};
   end

`ifdef RING_METERS_EN
   logic [31:0] meters [16];
   logic [31:0] meter_p0;
   logic        met_p0;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) meters[i] <= '0;
      end else begin
         meters[ring_type] <= meters[ring_type] + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      met_p0   <= cur_met;
      meter_p0 <= meters[{cur_line[0], beat}];
   end

   assign ret_word = dead_p0 ? IDLE_WORD : (met_p0 ? meter_p0 : mem_rdata);
`else
   assign ret_word = dead_p0 ? IDLE_WORD : mem_rdata;
`endif

   // stage p0: beat issued this cycle; memory answers during the next cycle
   always_ff @(posedge clk) begin
      if (rst) vld_p0 <= 1'b0;
      else     vld_p0 <= (state == BURST) && cur_rd;
   end

   always_ff @(posedge clk) begin
      dest_p0 <= cur_src;
      dead_p0 <= cur_bad;
   end

   // stage p1: registered return bus into core 1
   always_ff @(posedge clk) begin
      if (rst || !vld_p0) begin
         rd_dest <= 4'd0;
         rd_data <= IDLE_WORD;
      end else begin
         rd_dest <= dest_p0;
         rd_data <= ret_word;
      end
   end

endmodule
